// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the copy-engine state type.
// Imported by the copy master and its bench.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_DONE
    } copy_state_t;

endpackage

// File: rtl/ahb_dmem_copy_master.sv
// AHB-Lite word-copy initiator: read one word, write it, advance.
// Single NONSEQ transfers only; all bus outputs are registered.
module ahb_dmem_copy_master
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              hclk,
    input  logic              hrst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len_words,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [3:0]        hprot,
    output logic [31:0]       hwdata,
    input  logic [31:0]       hrdata,
    input  logic              hready,
    input  logic [1:0]        hresp
);

    copy_state_t       state;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [LEN_W-1:0]  count;
    logic [31:0]       data_q;

    logic [ADDR_W-1:0] src_next;
    logic [ADDR_W-1:0] dst_next;
    logic [ADDR_W-1:0] src_align;
    logic [ADDR_W-1:0] dst_align;
    logic              resp_err;

    assign hsize  = HSIZE_WORD;
    assign hburst = HBURST_SINGLE;
    assign hprot  = HPROT_DATA_PRIV;

    // Pointer arithmetic wraps modulo 2^ADDR_W by construction.
    assign src_next  = src_ptr + ADDR_W'(4);
    assign dst_next  = dst_ptr + ADDR_W'(4);
    assign src_align = {src_addr[ADDR_W-1:2], 2'b00};
    assign dst_align = {dst_addr[ADDR_W-1:2], 2'b00};
    assign resp_err  = (hresp == HRESP_ERROR);

    // Copy FSM: drives the registered bus outputs and status flags.
    always_ff @(posedge hclk) begin
        if (hrst) begin
            state   <= ST_IDLE;
            src_ptr <= '0;
            dst_ptr <= '0;
            count   <= '0;
            data_q  <= '0;
            haddr   <= '0;
            htrans  <= HTRANS_IDLE;
            hwrite  <= 1'b0;
            hwdata  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        err  <= 1'b0;
                        busy <= 1'b1;
                        if (len_words != '0) begin
                            src_ptr <= src_align;
                            dst_ptr <= dst_align;
                            count   <= len_words;
                            haddr   <= src_align;
                            hwrite  <= 1'b0;
                            htrans  <= HTRANS_NONSEQ;
                            state   <= ST_RD_ADDR;
                        end else begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_RD_ADDR: begin
                    if (hready) begin
                        htrans <= HTRANS_IDLE;
                        state  <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    // An ERROR first shows with hready low; act on
                    // the completing cycle only.
                    if (hready) begin
                        if (resp_err) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            data_q <= hrdata;
                            haddr  <= dst_ptr;
                            hwrite <= 1'b1;
                            htrans <= HTRANS_NONSEQ;
                            state  <= ST_WR_ADDR;
                        end
                    end
                end
                ST_WR_ADDR: begin
                    if (hready) begin
                        htrans <= HTRANS_IDLE;
                        hwdata <= data_q;
                        state  <= ST_WR_DATA;
                    end
                end
                ST_WR_DATA: begin
                    if (hready) begin
                        if (resp_err) begin
                            err    <= 1'b1;
                            done   <= 1'b1;
                            hwrite <= 1'b0;
                            state  <= ST_DONE;
                        end else begin
                            src_ptr <= src_next;
                            dst_ptr <= dst_next;
                            count   <= count - LEN_W'(1);
                            hwrite  <= 1'b0;
                            if (count == LEN_W'(1)) begin
                                done  <= 1'b1;
                                state <= ST_DONE;
                            end else begin
                                haddr  <= src_next;
                                htrans <= HTRANS_NONSEQ;
                                state  <= ST_RD_ADDR;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy   <= 1'b0;
                    htrans <= HTRANS_IDLE;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_dmem_copy_master.sv
// Bench for ahb_dmem_copy_master: AHB slave model with waits and
// error injection, reference copy model, scoreboard monitor.
module tb_ahb_dmem_copy_master;
    import ahb_pkg::*;

    logic        hclk = 1'b0;
    logic        hrst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [15:0] len_words = '0;
    logic        busy, done, err;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic [1:0]  hresp;

    ahb_dmem_copy_master #(.ADDR_W(32), .LEN_W(16)) dut (
        .hclk(hclk), .hrst(hrst), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr),
        .len_words(len_words),
        .busy(busy), .done(done), .err(err),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
        .hsize(hsize), .hburst(hburst), .hprot(hprot),
        .hwdata(hwdata), .hrdata(hrdata),
        .hready(hready), .hresp(hresp)
    );

    always #5 hclk = ~hclk;

    int cyc = 0;
    always @(posedge hclk) cyc <= cyc + 1;

    // Slave model
    logic [31:0] rd_mem [256];
    logic [31:0] wr_mem [256];
    int          wait_n = 0;
    bit          inj = 1'b0;
    logic [31:0] inj_addr = '0;
    logic        s_act = 1'b0;
    logic        s_wr = 1'b0;
    logic        s_err = 1'b0;
    logic [31:0] s_addr = '0;
    int          s_cnt = 0;

    always_comb begin
        hready = 1'b1;
        hresp  = HRESP_OKAY;
        hrdata = 32'h0BAD_0BAD;
        if (s_act) begin
            if (s_err) begin
                hresp  = HRESP_ERROR;
                hready = (s_cnt == 1);
            end else begin
                hready = (s_cnt >= wait_n);
                if (!s_wr && hready) hrdata = rd_mem[s_addr[9:2]];
            end
        end
    end

    always @(posedge hclk) begin
        if (hrst) begin
            s_act <= 1'b0;
            s_err <= 1'b0;
            s_cnt <= 0;
        end else if (s_act && !hready) begin
            s_cnt <= s_cnt + 1;
        end else begin
            if (s_act && s_wr && !s_err) wr_mem[s_addr[9:2]] <= hwdata;
            s_act  <= (htrans == HTRANS_NONSEQ);
            s_addr <= haddr;
            s_wr   <= hwrite;
            s_cnt  <= 0;
            s_err  <= inj && !hwrite && (haddr == inj_addr)
                      && (htrans == HTRANS_NONSEQ);
        end
    end

    // Scoreboard
    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
    } xfer_t;
    typedef struct {
        int   cyc;
        logic err;
    } done_t;

    xfer_t exp_tr[$];
    done_t exp_dn[$];
    int    errors = 0;
    int    checks = 0;
    logic [31:0] pend_wdata = '0;
    logic [31:0] prev_haddr = '0;
    logic        prev_hwrite = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)",
                     name, act, expv, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a transfer
    // or a done pulse.
    always @(negedge hclk) begin : mon
        xfer_t x;
        done_t d;
        if (!hrst) begin
            if (htrans == HTRANS_NONSEQ && hready) begin
                if (exp_tr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_xfer: addr %h write %b",
                             haddr, hwrite);
                end else begin
                    x = exp_tr.pop_front();
                    chk("xfer_addr", haddr, x.addr);
                    chk("xfer_write", 32'(hwrite), 32'(x.wr));
                    chk("hsize", 32'(hsize), 32'(HSIZE_WORD));
                    chk("hburst", 32'(hburst), 32'(HBURST_SINGLE));
                    chk("hprot", 32'(hprot), 32'(HPROT_DATA_PRIV));
                    if (x.wr) pend_wdata = x.data;
                end
            end
            if (s_act && s_wr && !s_err) chk("hwdata", hwdata, pend_wdata);
            if (s_act && !hready) begin
                chk("wait_htrans", 32'(htrans), 32'(HTRANS_IDLE));
                chk("wait_haddr", haddr, prev_haddr);
                chk("wait_hwrite", 32'(hwrite), 32'(prev_hwrite));
            end
            if (done) begin
                if (exp_dn.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: cyc %0d", cyc);
                end else begin
                    d = exp_dn.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(d.cyc));
                    chk("done_err", 32'(err), 32'(d.err));
                end
            end
            prev_haddr  = haddr;
            prev_hwrite = hwrite;
        end
    end

    // Reference copy model and driver
    task automatic run_copy(input logic [31:0] s, input logic [31:0] dd,
                            input int len, input int w, input bit en_err,
                            input logic [31:0] ea, input int poke);
        logic [31:0] s0, d0, ra;
        bit hit;
        int kerr, dc, a0;
        bit fin;
        s0 = {s[31:2], 2'b00};
        d0 = {dd[31:2], 2'b00};
        @(negedge hclk);
        wait_n    = w;
        inj       = en_err;
        inj_addr  = ea;
        src_addr  = s;
        dst_addr  = dd;
        len_words = 16'(len);
        start     = 1'b1;
        @(posedge hclk);
        #1;
        a0 = cyc;
        start = 1'b0;
        hit = 1'b0;
        kerr = 0;
        for (int i = 0; i < len; i++) begin
            ra = s0 + 32'(4 * i);
            exp_tr.push_back('{ra, 1'b0, 32'h0});
            if (en_err && ra == ea) begin
                hit = 1'b1;
                kerr = i;
                break;
            end
            exp_tr.push_back('{d0 + 32'(4 * i), 1'b1, rd_mem[ra[9:2]]});
        end
        if (len == 0) dc = 1;
        else if (hit) dc = kerr * (4 + 2 * w) + 4;
        else dc = len * (4 + 2 * w) + 1;
        exp_dn.push_back('{a0 - 1 + dc, hit});
        fin = 1'b0;
        for (int k = 1; k <= 3000; k++) begin
            @(negedge hclk);
            start = 1'b0;
            if (!busy) begin
                fin = 1'b1;
                break;
            end
            if (k == poke) begin
                start     = 1'b1;
                src_addr  = 32'h3C0;
                dst_addr  = 32'h3E0;
                len_words = 16'd7;
            end
        end
        if (!fin) begin
            errors++;
            $display("FAIL copy_timeout: busy still high");
        end
        chk("err_sticky", 32'(err), 32'(hit));
        chk("xfer_drained", 32'(exp_tr.size()), 32'd0);
        chk("done_drained", 32'(exp_dn.size()), 32'd0);
        exp_tr.delete();
        exp_dn.delete();
    endtask

    task automatic reset_mid_copy();
        bit seen;
        @(negedge hclk);
        wait_n    = 0;
        inj       = 1'b0;
        src_addr  = 32'h100;
        dst_addr  = 32'h380;
        len_words = 16'd2;
        start     = 1'b1;
        @(posedge hclk);
        #1;
        start = 1'b0;
        exp_tr.push_back('{32'h100, 1'b0, 32'h0});
        exp_tr.push_back('{32'h380, 1'b1, rd_mem[8'h40]});
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge hclk);
            if (htrans == HTRANS_NONSEQ && hwrite) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rst_saw_wr_addr", 32'(seen), 32'd1);
        #1;
        hrst = 1'b1;
        @(posedge hclk);
        #1;
        chk("rst_htrans", 32'(htrans), 32'(HTRANS_IDLE));
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge hclk);
        hrst = 1'b0;
        repeat (10) @(negedge hclk);
        chk("rst_xfer_drained", 32'(exp_tr.size()), 32'd0);
        exp_tr.delete();
    endtask

    initial begin
        logic [31:0] rs, rd, ea;
        int rl, rw;
        bit re;
        for (int i = 0; i < 256; i++) rd_mem[i] = $urandom;
        for (int i = 0; i < 4; i++) rd_mem[8'h40 + i] = 32'hA0 + 32'(i);

        repeat (3) @(posedge hclk);
        @(negedge hclk);
        chk("reset_htrans", 32'(htrans), 32'd0);
        chk("reset_hwrite", 32'(hwrite), 32'd0);
        chk("reset_haddr", haddr, 32'd0);
        chk("reset_hwdata", hwdata, 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        hrst = 1'b0;

        run_copy(32'h100, 32'h200, 4, 0, 1'b0, 32'h0, 0);
        for (int i = 0; i < 4; i++)
            chk("dst_word", wr_mem[8'h80 + i], 32'hA0 + 32'(i));

        run_copy(32'h120, 32'h240, 2, 2, 1'b0, 32'h0, 0);
        run_copy(32'h100, 32'h260, 3, 0, 1'b1, 32'h104, 0);
        run_copy(32'h000, 32'h280, 0, 0, 1'b0, 32'h0, 0);
        run_copy(32'h140, 32'h2C0, 4, 1, 1'b0, 32'h0, 3);
        run_copy(32'hFFFF_FFFC, 32'h300, 2, 0, 1'b0, 32'h0, 0);
        run_copy(32'h100, 32'h260, 3, 1, 1'b1, 32'h100, 0);
        reset_mid_copy();

        for (int t = 0; t < 8; t++) begin
            rs = 32'($urandom_range(0, 47) << 2) | 32'($urandom_range(0, 3));
            rd = 32'h200 + 32'($urandom_range(0, 47) << 2)
                 | 32'($urandom_range(0, 3));
            rl = $urandom_range(1, 12);
            rw = $urandom_range(0, 3);
            re = ($urandom_range(0, 2) == 0);
            ea = {rs[31:2], 2'b00} + 32'($urandom_range(0, rl - 1) * 4);
            run_copy(rs, rd, rl, rw, re, ea, (t % 3 == 1) ? 2 : 0);
        end

        repeat (5) @(negedge hclk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
